// File: rtl/counter_pkg.sv
// Shared opcode and FSM encodings for the counter command scheduler.
package counter_pkg;

  typedef enum logic [1:0] {
    OP_LOAD      = 2'b00,
    OP_STEP_UP   = 2'b01,
    OP_STEP_DOWN = 2'b10,
    OP_CLEAR     = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  function automatic logic is_step(op_e op);
    return (op == OP_STEP_UP) || (op == OP_STEP_DOWN);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin selector: first asserted req at or after ptr wins, one-hot out.
// Purely combinational; no backpressure, the caller decides when to consume the grant.
module rr_arbiter #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] ptr,
  output logic [NREQ-1:0]         gnt
);
  localparam int PW = $clog2(NREQ);

  logic [PW-1:0] idx;
  logic          found;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      idx = PW'((int'(ptr) + k) % NREQ);
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/counter_cmd_scheduler.sv
// Arbitrates requester commands onto one shared up/down counter; grant 1 cycle after sampling,
// command takes 1 + max(1,N) + 1 cycles; requests are held off (ignored) until the FSM is back in IDLE.
module counter_cmd_scheduler
  import counter_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req,
  input  logic [2*NREQ-1:0]     req_op,
  input  logic [WIDTH*NREQ-1:0] req_arg,
  output logic [NREQ-1:0]       gnt,
  output logic [NREQ-1:0]       done,
  output logic                  busy,
  output logic                  cnt_clear,
  output logic                  cnt_load,
  output logic                  cnt_enable,
  output logic                  cnt_up_down,
  output logic [WIDTH-1:0]      cnt_data
);
  localparam int PW = $clog2(NREQ);

  state_e           state_q, state_d;
  op_e              op_q, op_d, sel_op;
  logic [PW-1:0]    rr_ptr_q, rr_ptr_d, win_q, win_d, sel_idx;
  logic [WIDTH-1:0] arg_q, arg_d, rem_q, rem_d, sel_arg;
  logic [NREQ-1:0]  sel_oh, gnt_d, done_d;
  logic             busy_d, clear_d, load_d, enable_d, up_down_d;
  logic [WIDTH-1:0] data_d;
  logic             take;

  rr_arbiter #(.NREQ(NREQ)) u_rr_arbiter (
    .req (req),
    .ptr (rr_ptr_q),
    .gnt (sel_oh)
  );

  always_comb begin
    sel_idx = '0;
    sel_op  = OP_LOAD;
    sel_arg = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (sel_oh[i]) begin
        sel_idx = PW'(i);
        sel_op  = op_e'(req_op[2*i +: 2]);
        sel_arg = req_arg[WIDTH*i +: WIDTH];
      end
    end
  end

  assign take = (state_q == ST_IDLE) && (req != '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    win_d    = win_q;
    op_d     = op_q;
    arg_d    = arg_q;
    rem_d    = rem_q;
    case (state_q)
      ST_IDLE: begin
        if (take) begin
          state_d  = ST_EXEC;
          win_d    = sel_idx;
          op_d     = sel_op;
          arg_d    = sel_arg;
          rem_d    = sel_arg;
          rr_ptr_d = (sel_idx == PW'(NREQ - 1)) ? '0 : sel_idx + PW'(1);
        end
      end
      ST_EXEC: begin
        // A zero-count step still spends one (idle) EXEC cycle.
        if (!is_step(op_q) || (rem_q <= WIDTH'(1))) state_d = ST_DONE;
        else                                        rem_d   = rem_q - WIDTH'(1);
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are computed from next-state values so they can be registered without lag.
  always_comb begin
    gnt_d     = take ? sel_oh : '0;
    done_d    = '0;
    if (state_d == ST_DONE) done_d[win_d] = 1'b1;
    busy_d    = (state_d != ST_IDLE);
    load_d    = (state_d == ST_EXEC) && (op_d == OP_LOAD);
    clear_d   = (state_d == ST_EXEC) && (op_d == OP_CLEAR);
    enable_d  = (state_d == ST_EXEC) && is_step(op_d) && (rem_d != '0);
    up_down_d = enable_d && (op_d == OP_STEP_UP);
    data_d    = load_d ? arg_d : '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr_q    <= '0;
      win_q       <= '0;
      op_q        <= OP_LOAD;
      arg_q       <= '0;
      rem_q       <= '0;
      gnt         <= '0;
      done        <= '0;
      busy        <= 1'b0;
      cnt_clear   <= 1'b0;
      cnt_load    <= 1'b0;
      cnt_enable  <= 1'b0;
      cnt_up_down <= 1'b0;
      cnt_data    <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      win_q       <= win_d;
      op_q        <= op_d;
      arg_q       <= arg_d;
      rem_q       <= rem_d;
      gnt         <= gnt_d;
      done        <= done_d;
      busy        <= busy_d;
      cnt_clear   <= clear_d;
      cnt_load    <= load_d;
      cnt_enable  <= enable_d;
      cnt_up_down <= up_down_d;
      cnt_data    <= data_d;
    end
  end

endmodule

// File: tb/tb_counter_cmd_scheduler.sv
// Scheduler driving a behavioural up/down counter; expected commands are queued, a monitor checks them.
module tb_counter_cmd_scheduler;

  localparam logic [1:0] LOAD = 2'b00, UP = 2'b01, DOWN = 2'b10, CLR = 2'b11;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [7:0]  req_op;
  logic [31:0] req_arg;
  logic [3:0]  gnt, done;
  logic        busy, cnt_clear, cnt_load, cnt_enable, cnt_up_down;
  logic [7:0]  cnt_data;
  logic [7:0]  count = 8'h00;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int         idx;
    logic [1:0] op;
    int         len;
    int         en;
    logic       up;
    logic [7:0] cnt;
    logic       aborted;
  } exp_t;

  exp_t exp_q[$];

  counter_cmd_scheduler #(.NREQ(4), .WIDTH(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .req_op      (req_op),
    .req_arg     (req_arg),
    .gnt         (gnt),
    .done        (done),
    .busy        (busy),
    .cnt_clear   (cnt_clear),
    .cnt_load    (cnt_load),
    .cnt_enable  (cnt_enable),
    .cnt_up_down (cnt_up_down),
    .cnt_data    (cnt_data)
  );

  always #5 clk = ~clk;

  // Shared counter as it sits at the parent level.
  always @(posedge clk) begin
    if (cnt_clear)       count <= 8'h00;
    else if (cnt_load)   count <= cnt_data;
    else if (cnt_enable) count <= cnt_up_down ? count + 8'h01 : count - 8'h01;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic push(input int idx, input logic [1:0] op, input int len, input int en,
                      input logic up, input logic [7:0] cnt, input logic aborted);
    exp_t e;
    e.idx = idx; e.op = op; e.len = len; e.en = en; e.up = up; e.cnt = cnt; e.aborted = aborted;
    exp_q.push_back(e);
  endtask

  task automatic issue(input int i, input logic [1:0] op, input logic [7:0] arg);
    req_op[2*i +: 2]  = op;
    req_arg[8*i +: 8] = arg;
    req[i]            = 1'b1;
  endtask

  task automatic drain(input int max_cyc);
    logic ok;
    ok = 1'b0;
    for (int c = 0; c < max_cyc && !ok; c++) begin
      @(negedge clk);
      req = req & ~gnt;
      if (req == '0 && !busy) ok = 1'b1;
    end
    chk("drain_timeout", {31'b0, ok}, 32'd1);
  endtask

  task automatic wait_gnt(input int i);
    logic ok;
    ok = 1'b0;
    for (int c = 0; c < 30 && !ok; c++) begin
      @(negedge clk);
      req = req & ~gnt;
      if (gnt[i]) ok = 1'b1;
    end
    chk("wait_gnt_timeout", {31'b0, ok}, 32'd1);
  endtask

  // Monitor: pops an expectation at each grant, accumulates EXEC activity, checks at done.
  exp_t cur;
  logic active = 1'b0;
  int   exec_len, en_cnt;
  logic ud_bad;

  initial begin
    forever begin
      @(negedge clk);
      if (reset !== 1'b1) begin
        if (active) chk("abandoned_cmd_expected", {31'b0, cur.aborted}, 32'd1);
        active = 1'b0;
      end else begin
        chk("ctl_exclusive", {31'b0, ($countones({cnt_clear, cnt_load, cnt_enable}) <= 1)}, 32'd1);
        chk("data_zero_unless_load", {31'b0, (cnt_load || cnt_data == 8'h00)}, 32'd1);
        if (gnt != 4'b0) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_gnt", {28'b0, gnt}, 32'd0);
          end else begin
            cur = exp_q.pop_front();
            chk("gnt_onehot", {28'b0, gnt}, 32'(1 << cur.idx));
            chk("load_with_gnt", {31'b0, cnt_load}, {31'b0, (cur.op == LOAD)});
            chk("clear_with_gnt", {31'b0, cnt_clear}, {31'b0, (cur.op == CLR)});
            active   = 1'b1;
            exec_len = 0;
            en_cnt   = 0;
            ud_bad   = 1'b0;
          end
        end
        if (active && done == 4'b0) begin
          exec_len++;
          if (cnt_enable) begin
            en_cnt++;
            if (cnt_up_down !== cur.up) ud_bad = 1'b1;
          end
        end
        if (done != 4'b0) begin
          if (!active) begin
            chk("unexpected_done", {28'b0, done}, 32'd0);
          end else begin
            chk("done_onehot", {28'b0, done}, 32'(1 << cur.idx));
            chk("done_not_aborted", {31'b0, cur.aborted}, 32'd0);
            chk("exec_cycles", exec_len, cur.len);
            chk("enable_cycles", en_cnt, cur.en);
            chk("direction", {31'b0, ud_bad}, 32'd0);
            chk("count_at_done", {24'b0, count}, {24'b0, cur.cnt});
            active = 1'b0;
          end
        end
      end
    end
  end

  initial begin
    reset   = 1'b1;
    req     = '0;
    req_op  = '0;
    req_arg = '0;
    #3 reset = 1'b0;
    #1;
    chk("reset_outputs", {gnt, done, busy, cnt_clear, cnt_load, cnt_enable, cnt_up_down, cnt_data},
        32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // LOAD 0x5A from requester 2
    push(2, LOAD, 1, 0, 1'b0, 8'h5A, 1'b0);
    issue(2, LOAD, 8'h5A);
    drain(20);

    // Preload 0xFE, then STEP_UP 3 wraps to 0x01
    push(0, LOAD, 1, 0, 1'b0, 8'hFE, 1'b0);
    issue(0, LOAD, 8'hFE);
    drain(20);
    push(0, UP, 3, 3, 1'b1, 8'h01, 1'b0);
    issue(0, UP, 8'd3);
    drain(20);

    // CLEAR from 3; requester 1 raises req mid-command and must wait for IDLE
    push(3, CLR, 1, 0, 1'b0, 8'h00, 1'b0);
    push(1, LOAD, 1, 0, 1'b0, 8'h33, 1'b0);
    issue(3, CLR, 8'h00);
    wait_gnt(3);
    issue(1, LOAD, 8'h33);
    drain(20);

    // STEP_DOWN 0: one idle EXEC cycle, count unchanged
    push(3, DOWN, 1, 0, 1'b0, 8'h33, 1'b0);
    issue(3, DOWN, 8'd0);
    drain(20);

    // All four with rr_ptr=0 -> 0,1,2,3
    push(0, LOAD, 1, 0, 1'b0, 8'h10, 1'b0);
    push(1, UP,   2, 2, 1'b1, 8'h12, 1'b0);
    push(2, DOWN, 1, 1, 1'b0, 8'h11, 1'b0);
    push(3, LOAD, 1, 0, 1'b0, 8'h80, 1'b0);
    issue(0, LOAD, 8'h10);
    issue(1, UP,   8'd2);
    issue(2, DOWN, 8'd1);
    issue(3, LOAD, 8'h80);
    drain(60);

    // Grant to 1 alone, then all four -> 2,3,0,1
    push(1, CLR, 1, 0, 1'b0, 8'h00, 1'b0);
    issue(1, CLR, 8'h00);
    drain(20);
    push(2, UP,   1, 1, 1'b1, 8'h01, 1'b0);
    push(3, DOWN, 2, 2, 1'b0, 8'hFF, 1'b0);
    push(0, LOAD, 1, 0, 1'b0, 8'h42, 1'b0);
    push(1, UP,   1, 0, 1'b1, 8'h42, 1'b0);
    issue(0, LOAD, 8'h42);
    issue(1, UP,   8'd0);
    issue(2, UP,   8'd1);
    issue(3, DOWN, 8'd2);
    drain(60);

    // Reset during the second cycle of STEP_UP 10
    push(2, UP, 10, 10, 1'b1, 8'h4C, 1'b1);
    issue(2, UP, 8'd10);
    wait_gnt(2);
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk("midexec_reset_outputs",
        {gnt, done, busy, cnt_clear, cnt_load, cnt_enable, cnt_up_down, cnt_data}, 32'd0);
    repeat (2) @(negedge clk);
    chk("count_after_abort", {24'b0, count}, 32'h43);
    reset = 1'b1;
    @(negedge clk);
    chk("idle_after_release", {31'b0, busy}, 32'd0);

    // rr_ptr back at 0: requester 0 beats 3
    push(0, LOAD, 1, 0, 1'b0, 8'h07, 1'b0);
    push(3, DOWN, 1, 1, 1'b0, 8'h06, 1'b0);
    issue(3, DOWN, 8'd1);
    issue(0, LOAD, 8'h07);
    drain(40);

    repeat (2) @(negedge clk);
    chk("expectations_left", exp_q.size(), 32'd0);
    chk("cmd_in_flight", {31'b0, active}, 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/counter_cmd_scheduler.md
COUNTER_CMD_SCHEDULER -- requirements
Module: counter_cmd_scheduler

Interface
REQ-001 Parameter NREQ, default 4, SHALL set the number of requester ports (2..8).
REQ-002 Parameter WIDTH, default 8, SHALL set the counter data width.
REQ-003 clk  in  1  SHALL be the single clock; all logic updates on its rising edge.
REQ-004 reset  in  1  SHALL be the asynchronous, active-low reset.
REQ-005 req  in  NREQ  SHALL carry one command-request bit per requester.
REQ-006 req_op  in  2*NREQ  SHALL carry one opcode per requester, slice i = [2i+1:2i]: 00 LOAD, 01 STEP_UP, 10 STEP_DOWN, 11 CLEAR.
REQ-007 req_arg  in  WIDTH*NREQ  SHALL carry one operand per requester: the load value, or the step count.
REQ-008 gnt  out  NREQ  SHALL be a one-hot, one-cycle pulse marking the accepted requester.
REQ-009 done  out  NREQ  SHALL be a one-hot, one-cycle pulse marking completion of that requester's command.
REQ-010 busy  out  1  SHALL be high whenever the state is not IDLE.
REQ-011 cnt_clear, cnt_load, cnt_enable, cnt_up_down  out  1 each  SHALL drive the shared counter's synchronous clear, load, enable and direction (1 = up) inputs.
REQ-012 cnt_data  out  WIDTH  SHALL drive the shared counter's load-data input.

Function
REQ-013 All outputs SHALL be registered.
REQ-014 The FSM SHALL have exactly three states: IDLE, EXEC, DONE.
REQ-015 IDLE with req != 0 at edge k:
  - SHALL select one requester by round-robin, starting at rr_ptr.
  - SHALL latch that requester's op and arg.
  - SHALL enter EXEC at cycle k+1.
REQ-016 gnt[i] SHALL be high only in the first EXEC cycle.
REQ-017 rr_ptr SHALL update to (winner+1) mod NREQ on each grant; it resets to 0.
REQ-018 Requesters SHALL hold req, req_op and req_arg stable until they see gnt.
REQ-019 req, req_op and req_arg SHALL be ignored outside IDLE.
REQ-020 LOAD: one EXEC cycle with cnt_load=1 and cnt_data=arg.
REQ-021 CLEAR: one EXEC cycle with cnt_clear=1.
REQ-022 STEP_UP/STEP_DOWN with arg=N>0:
  - exactly N consecutive EXEC cycles with cnt_enable=1;
  - cnt_up_down=1 for STEP_UP, 0 for STEP_DOWN;
  - a WIDTH-bit remaining-count register tracks the steps left;
  - EXEC exits after the cycle in which remaining==1.
REQ-023 STEP with arg=0: one EXEC cycle with all cnt_* controls low, then a normal DONE.
REQ-024 At most one of cnt_clear, cnt_load and cnt_enable SHALL be high in any cycle; all are low outside EXEC.
REQ-025 cnt_data SHALL be 0 outside LOAD cycles.
REQ-026 DONE SHALL last one cycle, pulse done[winner], then return to IDLE.
REQ-027 Arbitration latency SHALL be 1 cycle. A command occupies 1 + max(1,N) + 1 cycles from sampling to IDLE.
REQ-028 Counter wrap-around is the counter's own behaviour; the scheduler SHALL NOT saturate or check the count value.

Reset
REQ-029 Asserting reset at any time, including mid-EXEC, SHALL asynchronously force:
  - state=IDLE and rr_ptr=0;
  - gnt=0, done=0, busy=0;
  - all cnt_* outputs to 0.
REQ-030 A command interrupted by reset SHALL be abandoned with no done pulse.
REQ-031 The first grant after reset release SHALL occur no earlier than the first rising edge with reset high.

Structure
REQ-032 The opcode encodings and the FSM state encoding SHALL be defined in the shared package counter_pkg.
REQ-033 The round-robin selector SHALL be a separate sub-module, rr_arbiter (NREQ-wide: req and pointer in, one-hot grant out).
REQ-034 The shared counter SHALL NOT be instantiated inside this block; it is connected at the parent level.

Verification
REQ-035 The bench SHALL connect the scheduler to the team's up/down counter and cover these scenarios:
  - Requester 2 issues LOAD 0x5A -> gnt[2] and cnt_load in the same cycle; done[2] one cycle later; count=0x5A.
  - Requester 0 issues STEP_UP 3 from 0xFE -> 3 cycles with cnt_enable=1 and cnt_up_down=1; count=0x01 (wrap); done[0] after the third step.
  - All four requesters request together with rr_ptr=0 -> grant order 0,1,2,3; the later order after a grant to 1 is 2,3,0,1.
  - STEP_DOWN 0 -> no cnt_enable pulse; done after exactly one EXEC cycle; count unchanged.
  - Reset asserted during cycle 2 of STEP_UP 10 -> all outputs 0 immediately; no done pulse; IDLE on release; next grant to requester 0.
  - CLEAR from requester 3 while requester 1 holds req -> requester 1 is ignored until IDLE, then granted; count=0 before requester 1 executes.
